// File: rtl/multiplexed_display_scanner_if.sv
// Display scanner bus: datapath-side values in, board-side digit/segment drive out.
// The scanner itself connects through the slave modport; whatever feeds it uses master.
interface multiplexed_display_scanner_if #(
    parameter int NUM_DIGITS = 4,
    parameter int PWM_BITS   = 3
);
    logic [4*NUM_DIGITS-1:0] hexValues;
    logic [NUM_DIGITS-1:0]   dpIn;
    logic [NUM_DIGITS-1:0]   digitEnable;
    logic [PWM_BITS-1:0]     brightness;
    logic [NUM_DIGITS-1:0]   digitSel;
    logic [6:0]              segment;
    logic                    dp;
    logic                    frameStart;

    modport master (
        output hexValues, dpIn, digitEnable, brightness,
        input  digitSel, segment, dp, frameStart
    );

    modport slave (
        input  hexValues, dpIn, digitEnable, brightness,
        output digitSel, segment, dp, frameStart
    );
endinterface

// File: rtl/multiplexed_display_scanner.sv
// N-digit time-multiplexed 7-segment scanner with hex decode, per-slot blanking,
// PWM brightness, per-digit enable/decimal point and a frame-synchronous snapshot
// of all display inputs. Every board-facing output is registered and active-low.
module multiplexed_display_scanner #(
    parameter int NUM_DIGITS   = 4,
    parameter int DIGIT_PERIOD = 12000,
    parameter int BLANK_CYCLES = 240,
    parameter int PWM_BITS     = 3
) (
    input  logic                            clk,
    input  logic                            reset,
    multiplexed_display_scanner_if.slave    bus
);

    localparam int DW  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PCW = (DIGIT_PERIOD > 1) ? $clog2(DIGIT_PERIOD) : 1;
    // Wide enough for (DIGIT_PERIOD-BLANK_CYCLES) * 2^PWM_BITS with no truncation.
    localparam int OW  = $clog2(DIGIT_PERIOD + 1) + PWM_BITS + 1;

    localparam logic [PCW-1:0] P_LAST = PCW'(DIGIT_PERIOD - 1);
    localparam logic [DW-1:0]  D_LAST = DW'(NUM_DIGITS - 1);
    localparam logic [OW-1:0]  ACTIVE = OW'(DIGIT_PERIOD - BLANK_CYCLES);
    localparam logic [OW-1:0]  BLANK  = OW'(BLANK_CYCLES);

    // Active-high gfedcba pattern for one hex nibble.
    function automatic logic [6:0] f_decode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'h3F;
            4'h1:    seg = 7'h06;
            4'h2:    seg = 7'h5B;
            4'h3:    seg = 7'h4F;
            4'h4:    seg = 7'h66;
            4'h5:    seg = 7'h6D;
            4'h6:    seg = 7'h7D;
            4'h7:    seg = 7'h07;
            4'h8:    seg = 7'h7F;
            4'h9:    seg = 7'h6F;
            4'hA:    seg = 7'h77;
            4'hB:    seg = 7'h7C;
            4'hC:    seg = 7'h39;
            4'hD:    seg = 7'h5E;
            4'hE:    seg = 7'h79;
            default: seg = 7'h71;
        endcase
        return seg;
    endfunction

    // Scan position: prescaler within a slot and current digit index.
    logic [PCW-1:0]          r_p;
    logic [DW-1:0]           r_d;
    logic                    r_load_pending;

    // Shadow copies of the inputs; the display only ever looks at these.
    logic [4*NUM_DIGITS-1:0] r_hex;
    logic [NUM_DIGITS-1:0]   r_dp_in;
    logic [NUM_DIGITS-1:0]   r_en;
    logic [PWM_BITS-1:0]     r_bright;

    // Registered board drive.
    logic [NUM_DIGITS-1:0]   r_digit_sel;
    logic [6:0]              r_segment;
    logic                    r_dp;
    logic                    r_frame_start;

    logic                    w_p_wrap;
    logic                    w_capture;
    logic [OW-1:0]           w_on_cycles;
    logic [OW-1:0]           w_p_ext;
    logic                    w_in_window;
    logic [3:0]              w_nibble;
    logic                    w_dp_sel;
    logic                    w_en_sel;
    logic [NUM_DIGITS-1:0]   w_sel_onehot;
    logic                    w_lit;

    assign w_p_wrap  = (r_p == P_LAST);
    // A capture happens at the very last cycle of a frame, or on the first clock
    // after reset so the display never shows the cleared shadow as real data.
    assign w_capture = (w_p_wrap && (r_d == D_LAST)) || r_load_pending;

    assign w_on_cycles = (ACTIVE * (OW'(r_bright) + OW'(1))) >> PWM_BITS;
    assign w_p_ext     = OW'(r_p);
    assign w_in_window = (w_p_ext >= BLANK) && (w_p_ext < (BLANK + w_on_cycles));

    // Pick the current digit's nibble, dp, enable and select bit from the shadow.
    always_comb begin
        w_nibble     = 4'h0;
        w_dp_sel     = 1'b0;
        w_en_sel     = 1'b0;
        w_sel_onehot = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_d == DW'(i)) begin
                w_nibble        = r_hex[i*4 +: 4];
                w_dp_sel        = r_dp_in[i];
                w_en_sel        = r_en[i];
                w_sel_onehot[i] = 1'b1;
            end
        end
    end

    assign w_lit = w_in_window && w_en_sel;

    // Prescaler and digit index advance; digit steps only when the prescaler wraps.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_p <= '0;
            r_d <= '0;
        end else if (w_p_wrap) begin
            r_p <= '0;
            r_d <= (r_d == D_LAST) ? '0 : r_d + DW'(1);
        end else begin
            r_p <= r_p + PCW'(1);
        end
    end

    // Frame-synchronous snapshot of every display input.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hex          <= '0;
            r_dp_in        <= '0;
            r_en           <= '0;
            r_bright       <= '0;
            r_load_pending <= 1'b1;
        end else if (w_capture) begin
            r_hex          <= bus.hexValues;
            r_dp_in        <= bus.dpIn;
            r_en           <= bus.digitEnable;
            r_bright       <= bus.brightness;
            r_load_pending <= 1'b0;
        end
    end

    // Output register: digit select, segments and dp all update on the same edge
    // from the same (p,d) state, so a digit is never driven with its neighbour's data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_digit_sel   <= '1;
            r_segment     <= 7'h7F;
            r_dp          <= 1'b1;
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= w_capture;
            if (w_lit) begin
                r_digit_sel <= ~w_sel_onehot;
                r_segment   <= ~f_decode(w_nibble);
                r_dp        <= ~w_dp_sel;
            end else begin
                r_digit_sel <= '1;
                r_segment   <= 7'h7F;
                r_dp        <= 1'b1;
            end
        end
    end

    assign bus.digitSel   = r_digit_sel;
    assign bus.segment    = r_segment;
    assign bus.dp         = r_dp;
    assign bus.frameStart = r_frame_start;

endmodule

// File: tb/tb_multiplexed_display_scanner.sv
// Bench for the display scanner at NUM_DIGITS=4, DIGIT_PERIOD=16, BLANK_CYCLES=2,
// PWM_BITS=3. Stimulus pushes the lit runs each frame should produce; a monitor
// rebuilds lit runs from the pins and pops/compares them one run at a time.
module tb_multiplexed_display_scanner;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    multiplexed_display_scanner_if #(.NUM_DIGITS(4), .PWM_BITS(3)) bus ();

    multiplexed_display_scanner #(
        .NUM_DIGITS  (4),
        .DIGIT_PERIOD(16),
        .BLANK_CYCLES(2),
        .PWM_BITS    (3)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        logic [3:0] sel;
        logic [6:0] seg;
        logic       dp;
        int         len;
        int         start;
    } run_t;

    run_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Active-high gfedcba patterns for 0..F and on-time for brightness 0..7
    // (14 * (b+1)) >> 3 with 14 = 16 - 2 active cycles per slot.
    logic [6:0] DEC [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    int         ON_TAB [8] = '{1, 3, 5, 7, 8, 10, 12, 14};

    // Directed vectors, each applied DLY cycles after a frameStart.
    logic [15:0] V_HEX [6] = '{16'h1234, 16'hFFFF, 16'hBD05, 16'h68AC, 16'h1234, 16'hE7D9};
    logic [3:0]  V_DP  [6] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b1111};
    logic [3:0]  V_EN  [6] = '{4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1011, 4'b1111};
    logic [2:0]  V_BR  [6] = '{3'd7, 3'd7, 3'd0, 3'd3, 3'd7, 3'd5};
    int          V_DLY [6] = '{0, 20, 0, 0, 0, 0};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Expected lit runs for one frame; trunc_d >= 0 cuts that digit's run short
    // and drops later digits (reset hit mid-slot).
    task automatic push_frame(input bit first, input logic [15:0] hx, input logic [3:0] dpi,
                              input logic [3:0] en, input logic [2:0] br,
                              input int trunc_d, input int trunc_len);
        run_t r;
        for (int d = 0; d < 4; d++) begin
            if (trunc_d >= 0 && d > trunc_d) break;
            if (en[d]) begin
                r.sel   = ~(4'b0001 << d);
                r.seg   = ~DEC[hx[d*4 +: 4]];
                r.dp    = ~dpi[d];
                r.len   = (d == trunc_d) ? trunc_len : ON_TAB[br];
                r.start = d*16 + (first ? 2 : 3);
                exp_q.push_back(r);
            end
        end
    endtask

    task automatic wait_fs();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.frameStart && n < 200);
        if (!bus.frameStart) begin
            n_cmp++;
            n_bad++;
            $display("FAIL frame_start_timeout: no frameStart within %0d cycles", n);
        end
    endtask

    task automatic apply(input int k);
        bus.hexValues   = V_HEX[k];
        bus.dpIn        = V_DP[k];
        bus.digitEnable = V_EN[k];
        bus.brightness  = V_BR[k];
    endtask

    // Monitor: rebuilds lit runs from the pins, checks dark cycles, one-cold
    // select and frame length.
    logic       in_run = 1'b0;
    logic [3:0] m_sel;
    logic [6:0] m_seg;
    logic       m_dp;
    int         m_len = 0;
    int         m_start = 0;
    int         cyc_since = 0;
    int         fs_count = 0;

    task automatic finish_run();
        run_t e;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_run: sel=%b seg=%h dp=%b len=%0d start=%0d",
                     m_sel, m_seg, m_dp, m_len, m_start);
        end else begin
            e = exp_q.pop_front();
            if (m_sel !== e.sel || m_seg !== e.seg || m_dp !== e.dp ||
                m_len != e.len || m_start != e.start) begin
                n_bad++;
                $display("FAIL lit_run: got sel=%b seg=%h dp=%b len=%0d start=%0d, expected sel=%b seg=%h dp=%b len=%0d start=%0d",
                         m_sel, m_seg, m_dp, m_len, m_start,
                         e.sel, e.seg, e.dp, e.len, e.start);
            end
        end
    endtask

    always @(negedge clk) begin
        cyc_since++;
        if (!reset) begin
            fs_count = 0;
        end else if (bus.frameStart) begin
            if (fs_count >= 2) chk("frame_length", cyc_since, 64);
            cyc_since = 0;
            fs_count++;
        end

        n_cmp++;
        if ($countones(~bus.digitSel) > 1) begin
            n_bad++;
            $display("FAIL one_cold: digitSel=%b", bus.digitSel);
        end
        if (bus.digitSel == 4'hF)
            chk("dark_seg_dp", {bus.segment, bus.dp}, {7'h7F, 1'b1});

        if (in_run) begin
            if (bus.digitSel == m_sel && bus.segment == m_seg && bus.dp == m_dp) begin
                m_len++;
            end else begin
                finish_run();
                in_run = 1'b0;
            end
        end
        if (!in_run && bus.digitSel != 4'hF) begin
            in_run  = 1'b1;
            m_sel   = bus.digitSel;
            m_seg   = bus.segment;
            m_dp    = bus.dp;
            m_len   = 1;
            m_start = cyc_since;
        end
    end

    initial begin
        apply(0);
        #23;
        chk("reset_digitSel", bus.digitSel, 4'hF);
        chk("reset_segment", bus.segment, 7'h7F);
        chk("reset_dp", bus.dp, 1'b1);
        chk("reset_frameStart", bus.frameStart, 1'b0);

        @(negedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        chk("first_clk_frameStart", bus.frameStart, 1'b1);
        push_frame(1'b1, V_HEX[0], V_DP[0], V_EN[0], V_BR[0], -1, 0);

        for (int k = 0; k < 6; k++) begin
            repeat (V_DLY[k]) @(negedge clk);
            #2 apply(k);
            wait_fs();
            push_frame(1'b0, V_HEX[k], V_DP[k], V_EN[k], V_BR[k],
                       (k == 5) ? 2 : -1, 6);
        end

        // Reset lands inside digit 2's lit window of the last frame.
        repeat (40) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("midslot_reset_digitSel", bus.digitSel, 4'hF);
        chk("midslot_reset_segment", bus.segment, 7'h7F);
        chk("midslot_reset_dp", bus.dp, 1'b1);
        chk("midslot_reset_frameStart", bus.frameStart, 1'b0);

        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        chk("rerelease_frameStart", bus.frameStart, 1'b1);
        push_frame(1'b1, V_HEX[5], V_DP[5], V_EN[5], V_BR[5], -1, 0);
        wait_fs();
        push_frame(1'b0, V_HEX[5], V_DP[5], V_EN[5], V_BR[5], -1, 0);
        wait_fs();
        repeat (5) @(negedge clk);
        chk("runs_outstanding", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
